// File: rtl/pipe_trace_buffer_if.sv
// Bus bundle for pipe_trace_buffer: capture control, trigger setup and readout handshake.
// The master side drives control and trigger setup; the slave side is the trace buffer.
`timescale 1ns/1ps
interface pipe_trace_buffer_if #(
   parameter int DATA_W   = 16,
   parameter int CHANNELS = 4,
   parameter int DEPTH    = 16
);
   localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int IDX_W = $clog2(DEPTH);

   logic                         arm;
   logic                         abort;
   logic                         sample_en;
   logic [CHANNELS*DATA_W-1:0]   ch_data;
   logic [SEL_W-1:0]             trig_ch_sel;
   logic [DATA_W-1:0]            trig_mask;
   logic [DATA_W-1:0]            trig_value;
   logic                         rd_req;
   logic                         rd_valid;
   logic [CHANNELS*DATA_W-1:0]   rd_data;
   logic [IDX_W-1:0]             rd_idx;
   logic [2:0]                   state;
   logic                         done;

   modport master (
      output arm, abort, sample_en, ch_data, trig_ch_sel, trig_mask, trig_value, rd_req,
      input  rd_valid, rd_data, rd_idx, state, done
   );

   modport slave (
      input  arm, abort, sample_en, ch_data, trig_ch_sel, trig_mask, trig_value, rd_req,
      output rd_valid, rd_data, rd_idx, state, done
   );
endinterface

// File: rtl/pipe_trace_buffer.sv
// Pipeline trace capture: circular buffer with pre-trigger history, masked-compare trigger
// and an oldest-first readout over a one-cycle-latency request/valid handshake.
`timescale 1ns/1ps
module pipe_trace_buffer #(
   parameter int DATA_W   = 16,
   parameter int CHANNELS = 4,
   parameter int DEPTH    = 16,
   parameter int PRE_TRIG = 8
) (
   input  logic               clk,
   input  logic               rst,
   pipe_trace_buffer_if.slave bus
);
   localparam int SEL_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int ENT_W  = CHANNELS * DATA_W;
   localparam int POST_N = DEPTH - PRE_TRIG;
   localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PRE_TRIG - 1);
   localparam logic [IDX_W-1:0] POST_LAST = IDX_W'(POST_N - 1);
   localparam logic [IDX_W-1:0] RD_LAST   = IDX_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRE   = 3'd1,
      S_ARMED = 3'd2,
      S_POST  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
   logic              rd_valid_q, rd_valid_d;
   logic [ENT_W-1:0]  rd_data_q, rd_data_d;
   logic [ENT_W-1:0]  mem [DEPTH];
   logic [DATA_W-1:0] trig_chan;
   logic [IDX_W-1:0]  rd_addr;
   logic              trig_hit;
   logic              wr_en;

   always_comb begin
      trig_chan = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (bus.trig_ch_sel == SEL_W'(k)) trig_chan = bus.ch_data[k*DATA_W +: DATA_W];
      end
   end

   assign trig_hit = bus.sample_en & (((trig_chan ^ bus.trig_value) & bus.trig_mask) == '0);
   // Once capture ends wr_ptr points at the oldest surviving entry, so reads start there.
   assign rd_addr  = wr_ptr_q + rd_cnt_q;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      cnt_d      = cnt_q;
      rd_cnt_d   = rd_cnt_q;
      rd_idx_d   = rd_idx_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      wr_en      = 1'b0;
      if (bus.abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.arm) begin
                  state_d  = S_PRE;
                  wr_ptr_d = '0;
                  cnt_d    = '0;
                  rd_cnt_d = '0;
               end
            end
            S_PRE: begin
               if (bus.sample_en) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + IDX_W'(1);
                  if (cnt_q == PRE_LAST) begin
                     state_d = S_ARMED;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + IDX_W'(1);
                  end
               end
            end
            S_ARMED: begin
               if (bus.sample_en) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + IDX_W'(1);
                  if (trig_hit) begin
                     state_d = (POST_N == 1) ? S_DONE : S_POST;
                     cnt_d   = IDX_W'(1);
                  end
               end
            end
            S_POST: begin
               if (bus.sample_en) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + IDX_W'(1);
                  if (cnt_q == POST_LAST) state_d = S_DONE;
                  else                    cnt_d   = cnt_q + IDX_W'(1);
               end
            end
            S_DONE: begin
               if (bus.rd_req) begin
                  rd_valid_d = 1'b1;
                  rd_data_d  = mem[rd_addr];
                  rd_idx_d   = rd_cnt_q;
                  rd_cnt_d   = rd_cnt_q + IDX_W'(1);
                  if (rd_cnt_q == RD_LAST) state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         cnt_q      <= '0;
         rd_cnt_q   <= '0;
         rd_idx_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         cnt_q      <= cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_idx_q   <= rd_idx_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Trace storage is plain RAM without reset; only entries written this capture are read.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= bus.ch_data;
   end

   assign bus.state    = state_q;
   assign bus.done     = (state_q == S_DONE);
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_idx   = rd_idx_q;
endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Self-checking bench for pipe_trace_buffer: table of capture scenarios plus hand-written
// abort, trigger-in-PRE and asynchronous-reset sequences; readout checked via a scoreboard queue.
`timescale 1ns/1ps
module tb_pipe_trace_buffer;
   localparam int DATA_W   = 16;
   localparam int CHANNELS = 4;
   localparam int DEPTH    = 16;
   localparam int PRE_TRIG = 8;

   typedef struct {
      logic [1:0]  sel;
      logic [15:0] mask;
      logic [15:0] value;
      bit          stall;
      int          chg_n;
      logic [15:0] chg_val;
      int          done_at;
   } cap_vec_t;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_miss;
   logic [63:0] sb[$];
   cap_vec_t    vecs[6];

   pipe_trace_buffer_if #(.DATA_W(DATA_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) bus();

   pipe_trace_buffer #(
      .DATA_W(DATA_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Channel k carries a distinct function of the sample number so every lane is checked.
   function automatic logic [63:0] pack(input int n);
      logic [15:0] v;
      v = 16'(n);
      return {v ^ 16'hA5A5, v + 16'd100, ~v, v};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic arm_capture(input cap_vec_t v);
      bus.trig_ch_sel = v.sel;
      bus.trig_mask   = v.mask;
      bus.trig_value  = v.value;
      bus.sample_en   = 1'b0;
      bus.arm         = 1'b1;
      sb.delete();
      step();
      bus.arm = 1'b0;
      check_output("arm_to_pre", 64'(bus.state), 64'd1);
   endtask

   task automatic drive_sample(input cap_vec_t v, input int n);
      if (n == v.chg_n) bus.trig_value = v.chg_val;
      bus.ch_data   = pack(n);
      bus.sample_en = v.stall ? (n % 2 == 0) : 1'b1;
      if (bus.sample_en) begin
         sb.push_back(pack(n));
         if (sb.size() > DEPTH) void'(sb.pop_front());
      end
      step();
   endtask

   task automatic apply_stimulus(input cap_vec_t v);
      arm_capture(v);
      for (int n = 0; n <= v.done_at; n++) begin
         drive_sample(v, n);
         check_output("done_timing", 64'(bus.done), 64'(n == v.done_at));
      end
      bus.sample_en = 1'b0;
   endtask

   task automatic read_out(input int cycles, input int exp_pulses, input bit expect_idle);
      int pulses;
      int idx;
      logic [63:0] exp;
      pulses = 0;
      idx    = 0;
      bus.rd_req = 1'b1;
      for (int c = 0; c < cycles; c++) begin
         step();
         if (bus.rd_valid) begin
            pulses++;
            if (sb.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("[TB] FAIL rd_extra: got rd_valid=1 with idx %0d, expected no more data", bus.rd_idx);
            end else begin
               exp = sb.pop_front();
               check_output("rd_data", bus.rd_data, exp);
               check_output("rd_idx", 64'(bus.rd_idx), 64'(idx));
               idx++;
            end
         end
      end
      if (expect_idle) bus.rd_req = 1'b0;
      check_output("rd_pulses", 64'(pulses), 64'(exp_pulses));
      if (expect_idle) check_output("idle_after_read", 64'(bus.state), 64'd0);
   endtask

   initial begin
      cap_vec_t hv;
      n_vec  = 0;
      n_miss = 0;
      vecs[0] = '{sel: 2'd0, mask: 16'hFFFF, value: 16'd20,   stall: 1'b0, chg_n: -1, chg_val: 16'd0,  done_at: 27};
      vecs[1] = '{sel: 2'd0, mask: 16'h0000, value: 16'd3,    stall: 1'b0, chg_n: -1, chg_val: 16'd0,  done_at: 15};
      vecs[2] = '{sel: 2'd2, mask: 16'hFFFF, value: 16'd120,  stall: 1'b0, chg_n: -1, chg_val: 16'd0,  done_at: 27};
      vecs[3] = '{sel: 2'd0, mask: 16'h000F, value: 16'd5,    stall: 1'b0, chg_n: -1, chg_val: 16'd0,  done_at: 28};
      vecs[4] = '{sel: 2'd1, mask: 16'hFFFF, value: 16'hFFEB, stall: 1'b0, chg_n: -1, chg_val: 16'd0,  done_at: 27};
      vecs[5] = '{sel: 2'd0, mask: 16'hFFFF, value: 16'd43,   stall: 1'b1, chg_n: 61, chg_val: 16'd62, done_at: 76};

      rst             = 1'b0;
      bus.arm         = 1'b0;
      bus.abort       = 1'b0;
      bus.sample_en   = 1'b0;
      bus.ch_data     = '0;
      bus.trig_ch_sel = '0;
      bus.trig_mask   = '0;
      bus.trig_value  = '0;
      bus.rd_req      = 1'b0;
      #12;
      rst = 1'b1;
      step();

      $display("[TB] reset state");
      check_output("rst_state", 64'(bus.state), 64'd0);
      check_output("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
      check_output("rst_rd_data", bus.rd_data, 64'd0);
      check_output("rst_rd_idx", 64'(bus.rd_idx), 64'd0);
      check_output("rst_done", 64'(bus.done), 64'd0);

      $display("[TB] rd_req and abort-with-arm in IDLE");
      bus.rd_req = 1'b1;
      step();
      check_output("idle_rd_valid", 64'(bus.rd_valid), 64'd0);
      bus.rd_req = 1'b0;
      bus.arm    = 1'b1;
      bus.abort  = 1'b1;
      step();
      check_output("abort_beats_arm", 64'(bus.state), 64'd0);
      bus.arm   = 1'b0;
      bus.abort = 1'b0;

      $display("[TB] table-driven captures");
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(vecs[i]);
         read_out(20, DEPTH, 1'b1);
         step();
         check_output("idle_no_valid", 64'(bus.rd_valid), 64'd0);
      end

      $display("[TB] trigger during PRE is ignored");
      hv = vecs[0];
      hv.value = 16'd3;
      arm_capture(hv);
      for (int n = 0; n <= 40; n++) begin
         drive_sample(hv, n);
         if (n == 3) check_output("pre_ignores_trig", 64'(bus.state), 64'd1);
      end
      check_output("still_armed", 64'(bus.state), 64'd2);
      check_output("not_done", 64'(bus.done), 64'd0);
      bus.sample_en = 1'b0;
      bus.abort     = 1'b1;
      step();
      bus.abort = 1'b0;
      check_output("abort_armed", 64'(bus.state), 64'd0);

      $display("[TB] abort in POST then re-arm");
      arm_capture(vecs[0]);
      for (int n = 0; n <= 24; n++) drive_sample(vecs[0], n);
      check_output("in_post", 64'(bus.state), 64'd3);
      bus.ch_data = pack(25);
      bus.abort   = 1'b1;
      step();
      bus.abort     = 1'b0;
      bus.sample_en = 1'b0;
      check_output("abort_post_state", 64'(bus.state), 64'd0);
      check_output("abort_post_valid", 64'(bus.rd_valid), 64'd0);
      bus.rd_req = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         check_output("abort_no_valid", 64'(bus.rd_valid), 64'd0);
      end
      bus.rd_req = 1'b0;
      apply_stimulus(vecs[0]);
      read_out(20, DEPTH, 1'b1);

      $display("[TB] asynchronous reset mid-readout");
      apply_stimulus(vecs[0]);
      read_out(4, 4, 1'b0);
      #2;
      rst = 1'b0;
      #0.5;
      check_output("async_rst_state", 64'(bus.state), 64'd0);
      check_output("async_rst_valid", 64'(bus.rd_valid), 64'd0);
      check_output("async_rst_data", bus.rd_data, 64'd0);
      check_output("async_rst_idx", 64'(bus.rd_idx), 64'd0);
      #0.5;
      rst        = 1'b1;
      bus.rd_req = 1'b0;
      sb.delete();
      step();
      check_output("post_rst_state", 64'(bus.state), 64'd0);
      check_output("post_rst_valid", 64'(bus.rd_valid), 64'd0);
      apply_stimulus(vecs[0]);
      read_out(20, DEPTH, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
